lsu_arbiter: RTL

- Two-requester arbiter and sequencer in front of lsu_new. It shares the single load/store unit between the pipeline MEM stage (port 0) and an auxiliary master such as a program loader or debug port (port 1).
- Each accepted request is latched and driven to the LSU for exactly one access cycle. Load data is registered back to the winning requester with a one-cycle valid pulse.
- Supports round-robin or fixed-priority arbitration, with a starvation guard for port 1.

---
 rtl/lsu_arbiter_if.sv | 40 ++++
 rtl/lsu_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/lsu_arbiter_if.sv
// Bundle of requester handshakes, LSU command bus and LSU read data seen by lsu_arbiter.
// The slave view belongs to the arbiter; the master view is the requesters plus the LSU.
interface lsu_arbiter_if;
    logic        i_req_0;
    logic        i_req_1;
    logic        i_wren_0;
    logic        i_wren_1;
    logic [31:0] i_addr_0;
    logic [31:0] i_addr_1;
    logic [31:0] i_wdata_0;
    logic [31:0] i_wdata_1;
    logic [2:0]  i_slt_sl_0;
    logic [2:0]  i_slt_sl_1;
    logic        o_gnt_0;
    logic        o_gnt_1;
    logic        o_rvalid_0;
    logic        o_rvalid_1;
    logic [31:0] o_rdata_0;
    logic [31:0] o_rdata_1;
    logic        o_lsu_wren;
    logic [31:0] o_lsu_addr;
    logic [31:0] o_st_data;
    logic [2:0]  o_slt_sl;
    logic [31:0] i_ld_data;
    logic        o_busy;

    modport slave (
        input  i_req_0, i_req_1, i_wren_0, i_wren_1, i_addr_0, i_addr_1,
               i_wdata_0, i_wdata_1, i_slt_sl_0, i_slt_sl_1, i_ld_data,
        output o_gnt_0, o_gnt_1, o_rvalid_0, o_rvalid_1, o_rdata_0, o_rdata_1,
               o_lsu_wren, o_lsu_addr, o_st_data, o_slt_sl, o_busy
    );

    modport master (
        output i_req_0, i_req_1, i_wren_0, i_wren_1, i_addr_0, i_addr_1,
               i_wdata_0, i_wdata_1, i_slt_sl_0, i_slt_sl_1, i_ld_data,
        input  o_gnt_0, o_gnt_1, o_rvalid_0, o_rvalid_1, o_rdata_0, o_rdata_1,
               o_lsu_wren, o_lsu_addr, o_st_data, o_slt_sl, o_busy
    );
endinterface

// File: rtl/lsu_arbiter.sv
// Shares one load/store unit between the MEM stage (port 0) and an auxiliary master (port 1).
// Each grant runs IDLE -> ACCESS -> RESP, so one access completes at most every three cycles.
module lsu_arbiter #(
    parameter int PRIO_MODE    = 0,
    parameter int STARVE_LIMIT = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    lsu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic [7:0] StarveLimit = 8'(STARVE_LIMIT);
    localparam logic [2:0] SltLw       = 3'b101;

    state_t      state_q, state_d;
    logic        cmdPort_q, cmdPort_d;
    logic        cmdWren_q, cmdWren_d;
    logic [31:0] cmdAddr_q, cmdAddr_d;
    logic [31:0] cmdWdata_q, cmdWdata_d;
    logic [2:0]  cmdSltSl_q, cmdSltSl_d;
    logic        lastW_q, lastW_d;
    logic [7:0]  starveCnt_q, starveCnt_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;

    logic        winner;
    logic        grant;
    logic        inAccess;

    // A lone requester always wins; a conflict goes to the port that did not win last
    // time (round-robin) or to port 0 unless port 1 has reached its starvation limit.
    always_comb begin
        winner = bus.i_req_1;
        if (bus.i_req_0 && bus.i_req_1) begin
            if (PRIO_MODE == 0) begin
                winner = ~lastW_q;
            end else begin
                winner = (starveCnt_q == StarveLimit);
            end
        end
    end

    assign grant = (state_q == IDLE) && (bus.i_req_0 || bus.i_req_1);

    always_comb begin
        state_d     = state_q;
        cmdPort_d   = cmdPort_q;
        cmdWren_d   = cmdWren_q;
        cmdAddr_d   = cmdAddr_q;
        cmdWdata_d  = cmdWdata_q;
        cmdSltSl_d  = cmdSltSl_q;
        lastW_d     = lastW_q;
        starveCnt_d = starveCnt_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;

        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d    = ACCESS;
                    cmdPort_d  = winner;
                    cmdWren_d  = winner ? bus.i_wren_1   : bus.i_wren_0;
                    cmdAddr_d  = winner ? bus.i_addr_1   : bus.i_addr_0;
                    cmdWdata_d = winner ? bus.i_wdata_1  : bus.i_wdata_0;
                    cmdSltSl_d = winner ? bus.i_slt_sl_1 : bus.i_slt_sl_0;
                    lastW_d    = winner;
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (!cmdWren_q) begin
                    if (cmdPort_q) begin
                        rdata1_d = bus.i_ld_data;
                    end else begin
                        rdata0_d = bus.i_ld_data;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Port 1 only accumulates denial while it waits in IDLE; dropping the request resets it.
        if (!bus.i_req_1 || (grant && winner)) begin
            starveCnt_d = 8'd0;
        end else if ((state_q == IDLE) && (starveCnt_q != StarveLimit)) begin
            starveCnt_d = starveCnt_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= IDLE;
            cmdPort_q   <= 1'b0;
            cmdWren_q   <= 1'b0;
            cmdAddr_q   <= 32'd0;
            cmdWdata_q  <= 32'd0;
            cmdSltSl_q  <= 3'd0;
            lastW_q     <= 1'b1;
            starveCnt_q <= 8'd0;
            rdata0_q    <= 32'd0;
            rdata1_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            cmdPort_q   <= cmdPort_d;
            cmdWren_q   <= cmdWren_d;
            cmdAddr_q   <= cmdAddr_d;
            cmdWdata_q  <= cmdWdata_d;
            cmdSltSl_q  <= cmdSltSl_d;
            lastW_q     <= lastW_d;
            starveCnt_q <= starveCnt_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    // Outside ACCESS the LSU sees a harmless word load at address 0, so no store can leak.
    assign inAccess       = (state_q == ACCESS);
    assign bus.o_lsu_wren = inAccess && cmdWren_q;
    assign bus.o_lsu_addr = inAccess ? cmdAddr_q  : 32'd0;
    assign bus.o_st_data  = inAccess ? cmdWdata_q : 32'd0;
    assign bus.o_slt_sl   = inAccess ? cmdSltSl_q : SltLw;

    assign bus.o_gnt_0    = grant && !winner;
    assign bus.o_gnt_1    = grant && winner;
    assign bus.o_rvalid_0 = (state_q == RESP) && !cmdPort_q;
    assign bus.o_rvalid_1 = (state_q == RESP) && cmdPort_q;
    assign bus.o_rdata_0  = rdata0_q;
    assign bus.o_rdata_1  = rdata1_q;
    assign bus.o_busy     = (state_q != IDLE);

endmodule
